muldiv_seq: RTL and testbench

Multi-cycle sequencer for the MIPS multiply/divide unit and the architectural HI/LO registers. It sits in EX beside the ALU and accepts the one-hot `mul_control` produced by the ALU control decoder for mult/multu/div/divu. It runs a 32-iteration shift-add multiply or restoring divide, then writes HI/LO. It also services mthi/mtlo writes and mfhi/mflo reads, and stalls the pipeline while an operation is in flight.

---
 rtl/muldiv_seq.sv | 137 +++++++++++++
 tb/tb_muldiv_seq.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// MIPS multiply/divide sequencer with architectural HI/LO registers.
// 32-iteration shift-add multiply and restoring divide; stalls EX while busy.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  mul_control,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        hilo_rd,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        b_zero;
    logic [31:0] opnd;
    logic [31:0] a_orig;
    logic [63:0] acc;

    logic        start_ok;
    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic        op_div;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] add_sum;
    logic [32:0] sub_diff;
    logic [63:0] prod;

    assign start_ok = start && (mul_control != 4'd0)
                    && ((mul_control & (mul_control - 4'd1)) == 4'd0);
    assign sgn    = mul_control[0] | mul_control[2];
    assign op_div = mul_control[2] | mul_control[3];
    assign a_neg  = sgn & op_a[31];
    assign b_neg  = sgn & op_b[31];
    assign abs_a  = a_neg ? -op_a : op_a;
    assign abs_b  = b_neg ? -op_b : op_b;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign add_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    // Divide: acc = {partial remainder, quotient shift register}
    assign sub_diff = {acc[63:32], acc[31]} - {1'b0, opnd};
    assign prod     = neg_q ? -acc : acc;

    assign busy  = (state != IDLE);
    assign stall = busy & (start | hi_we | lo_we | hilo_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            opnd   <= 32'd0;
            a_orig <= 32'd0;
            acc    <= 64'd0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= 5'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start_ok) begin
                        state  <= CALC;
                        cnt    <= 5'd0;
                        is_div <= op_div;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        b_zero <= (op_b == 32'd0);
                        a_orig <= op_a;
                        if (op_div) begin
                            opnd <= abs_b;
                            acc  <= {32'd0, abs_a};
                        end else begin
                            opnd <= abs_a;
                            acc  <= {32'd0, abs_b};
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        if (!sub_diff[32])
                            acc <= {sub_diff[31:0], acc[30:0], 1'b1};
                        else
                            acc <= {acc[62:0], 1'b0};
                    end else begin
                        acc <= {add_sum, acc[31:1]};
                    end
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (is_div) begin
                        if (b_zero) begin
                            hi <= a_orig;
                            lo <= 32'hFFFF_FFFF;
                        end else begin
                            lo <= neg_q ? -acc[31:0] : acc[31:0];
                            hi <= neg_r ? -acc[63:32] : acc[63:32];
                        end
                    end else begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI:LO pushed at issue,
// popped and compared when done pulses.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  mul_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        hilo_rd;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .mul_control(mul_control),
        .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .hilo_rd(hilo_rd), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [3:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb;
        logic [31:0] q, r;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        qa = $signed(a);
        qb = $signed(b);
        if (c == 4'b0001) return sa * sb;
        if (c == 4'b0010) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (c == 4'b0100) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return {32'd0, 32'h8000_0000};
            q = qa / qb;
            r = qa % qb;
            return {r, q};
        end
        q = a / b;
        r = a % b;
        return {r, q};
    endfunction

    task automatic issue(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        @(negedge clk);
        start = 1'b1;
        mul_control = c;
        op_a = a;
        op_b = b;
        if (push) sb_q.push_back(model(c, a, b));
        @(negedge clk);
        start = 1'b0;
        mul_control = 4'd0;
    endtask

    // Returns at the first negedge with done=1 (or at the bound);
    // cyc counts cycles after the start cycle.
    task automatic wait_done(output int cyc, output int busy_n);
        cyc = 1;
        busy_n = 0;
        forever begin
            if (busy) busy_n++;
            if (done || cyc >= 60) break;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        mul_control = 4'd0;
        op_a = 32'd0;
        op_b = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        hilo_rd = 1'b0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, stall} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 000", {busy, done, stall});
        end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++;
            $display("FAIL reset_hilo got %h want 0", {hi, lo});
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_ignore;
        logic [3:0] bad_ctl [2];
        bad_ctl[0] = 4'b0011;
        bad_ctl[1] = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            issue(bad_ctl[i], 32'd5, 32'd6, 0);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore_ctl%0d busy got %b want 0", i, busy);
            end
        end
    endtask

    task automatic test_ops;
        logic [3:0]  c [5];
        logic [31:0] a [5];
        logic [31:0] b [5];
        logic [63:0] exp;
        int cyc, bn;
        c[0] = 4'b0010; a[0] = 32'hFFFF_FFFF; b[0] = 32'hFFFF_FFFF;
        c[1] = 4'b0001; a[1] = 32'hFFFF_FFFD; b[1] = 32'd5;
        c[2] = 4'b0100; a[2] = 32'hFFFF_FFF9; b[2] = 32'd2;
        c[3] = 4'b0100; a[3] = 32'h8000_0000; b[3] = 32'hFFFF_FFFF;
        c[4] = 4'b1000; a[4] = 32'd100;       b[4] = 32'd0;
        for (int i = 0; i < 5; i++) begin
            issue(c[i], a[i], b[i], 1);
            wait_done(cyc, bn);
            checks++;
            if (!done || cyc != 34) begin
                errors++;
                $display("FAIL op%0d_latency got %0d want 34", i, cyc);
            end
            checks++;
            if (bn != 33) begin
                errors++;
                $display("FAIL op%0d_busy_cycles got %0d want 33", i, bn);
            end
            exp = sb_q.pop_front();
            checks++;
            if ({hi, lo} !== exp) begin
                errors++;
                $display("FAIL op%0d_result got %h want %h", i, {hi, lo}, exp);
            end
            {m_hi, m_lo} = exp;
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL op%0d_done_pulse got %b want 0", i, done);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0]  c;
        logic [31:0] a, b;
        logic [63:0] exp;
        int cyc, bn;
        for (int i = 0; i < 10; i++) begin
            c = 4'b0001 << $urandom_range(0, 3);
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (i == 0) b = 32'h8000_0000;
            issue(c, a, b, 1);
            wait_done(cyc, bn);
            exp = sb_q.pop_front();
            checks++;
            if (!done || {hi, lo} !== exp) begin
                errors++;
                $display("FAIL rand%0d ctl %b a %h b %h got %h want %h",
                         i, c, a, b, {hi, lo}, exp);
            end
            {m_hi, m_lo} = exp;
        end
    endtask

    task automatic test_stall;
        logic [63:0] exp;
        int cyc, bad;
        issue(4'b0010, 32'd6, 32'd7, 1);
        hilo_rd = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_1234;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_busy got %b want 1", stall);
        end
        bad = 0;
        cyc = 1;
        while (!done && cyc < 60) begin
            if (lo !== m_lo) bad++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_lo_held got %0d changes want 0", bad);
        end
        checks++;
        if (!done || cyc != 34) begin
            errors++;
            $display("FAIL stall_latency got %0d want 34", cyc);
        end
        exp = sb_q.pop_front();
        checks++;
        if ({hi, lo} !== exp) begin
            errors++;
            $display("FAIL stall_result got %h want %h", {hi, lo}, exp);
        end
        {m_hi, m_lo} = exp;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle got %b want 0", stall);
        end
        @(negedge clk);
        lo_we = 1'b0;
        hilo_rd = 1'b0;
        m_lo = 32'h0000_1234;
        checks++;
        if (lo !== m_lo) begin
            errors++;
            $display("FAIL mtlo_after got %h want %h", lo, m_lo);
        end
    endtask

    task automatic test_flush;
        bit seen;
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        m_hi = 32'hA5A5_A5A5;
        m_lo = 32'hA5A5_A5A5;
        checks++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
            errors++;
            $display("FAIL preload got %h want %h", {hi, lo}, {m_hi, m_lo});
        end
        issue(4'b0001, 32'd3, 32'd4, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy got %b want 0", busy);
        end
        seen = done;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_done got 1 want 0");
        end
        checks++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
            errors++;
            $display("FAIL flush_hilo got %h want %h", {hi, lo}, {m_hi, m_lo});
        end
    endtask

    task automatic test_flush_fix;
        issue(4'b0100, 32'd100, 32'd7, 0);
        repeat (32) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL fix_busy got %b want 1", busy);
        end
        flush = 1'b1;
        start = 1'b1;
        mul_control = 4'b0010;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        mul_control = 4'd0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL fix_flush_ctl got %b want 00", {busy, done});
        end
        checks++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
            errors++;
            $display("FAIL fix_flush_hilo got %h want %h", {hi, lo}, {m_hi, m_lo});
        end
    endtask

    task automatic test_reset_midop;
        issue(4'b1000, 32'd1000, 32'd3, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_ctl got %b want 00", {busy, done});
        end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_hilo got %h want 0", {hi, lo});
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp;
        int cyc, bn;
        issue(4'b1000, 32'd1000, 32'd7, 1);
        start = 1'b1;
        mul_control = 4'b0001;
        op_a = 32'h8000_0000;
        op_b = 32'h8000_0000;
        sb_q.push_back(model(4'b0001, 32'h8000_0000, 32'h8000_0000));
        wait_done(cyc, bn);
        exp = sb_q.pop_front();
        checks++;
        if (!done || cyc != 34 || {hi, lo} !== exp) begin
            errors++;
            $display("FAIL b2b_first cyc %0d got %h want %h", cyc, {hi, lo}, exp);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall_idle got %b want 0", stall);
        end
        @(negedge clk);
        start = 1'b0;
        mul_control = 4'd0;
        wait_done(cyc, bn);
        exp = sb_q.pop_front();
        checks++;
        if (!done || cyc != 34 || {hi, lo} !== exp) begin
            errors++;
            $display("FAIL b2b_second cyc %0d got %h want %h", cyc, {hi, lo}, exp);
        end
    endtask

    initial begin
        test_reset;
        test_ignore;
        test_ops;
        test_random;
        test_stall;
        test_flush;
        test_flush_fix;
        test_reset_midop;
        test_back_to_back;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
